// File: rtl/score_digit_converter.sv
// Sequential double-dabble binary-to-BCD converter for the score display, with a one-deep pending slot.
// Digits are committed at a frame boundary (or right after conversion when SYNC_TO_FRAME=0) so glyphs never tear.
module score_digit_converter #(
  parameter int SCORE_W       = 10,
  parameter int MAX_SCORE     = 999,
  parameter int SYNC_TO_FRAME = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [SCORE_W-1:0] score,
  input  logic               score_valid,
  input  logic               frame_start,
  output logic               busy,
  output logic [3:0]         digit_hund,
  output logic [3:0]         digit_tens,
  output logic [3:0]         digit_ones,
  output logic               digits_valid,
  output logic               overflow
);

  localparam logic [SCORE_W-1:0] MAX_LIM  = SCORE_W'(MAX_SCORE);
  localparam logic [3:0]         LAST_CNT = 4'(SCORE_W - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, HOLD} state_t;

  state_t             state, state_nxt;
  logic [SCORE_W-1:0] bin_q;
  logic [11:0]        bcd_q;
  logic [3:0]         cnt_q;
  logic               clamp_q;
  logic               pend_vld_q;
  logic [SCORE_W-1:0] pend_val_q;
  logic               pend_ovf_q;

  logic               in_ovf;
  logic [SCORE_W-1:0] in_val;
  logic [11:0]        bcd_adj;
  logic [11:0]        bcd_shift;
  logic [SCORE_W-1:0] bin_shift;
  logic               commit;
  logic               start_conv;
  logic [SCORE_W-1:0] ld_val;
  logic               ld_ovf;

  always_comb begin
    in_ovf = (score > MAX_LIM);
    in_val = in_ovf ? MAX_LIM : score;
  end

  // Double-dabble step: add 3 to any nibble >= 5, then shift {bcd, bin} left by one.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    {bcd_shift, bin_shift} = {bcd_adj, bin_q} << 1;
  end

  always_comb begin
    commit     = (state == HOLD) && (frame_start || (SYNC_TO_FRAME == 0));
    start_conv = ((state == IDLE) && score_valid) || (commit && (score_valid || pend_vld_q));
    // A request on the commit edge is newer than anything in the slot, so it wins.
    ld_val     = score_valid ? in_val : pend_val_q;
    ld_ovf     = score_valid ? in_ovf : pend_ovf_q;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (score_valid) state_nxt = CONVERT;
      CONVERT: if (cnt_q == LAST_CNT) state_nxt = HOLD;
      HOLD:    if (commit) state_nxt = (score_valid || pend_vld_q) ? CONVERT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      clamp_q <= 1'b0;
    end else if (start_conv) begin
      bin_q   <= ld_val;
      bcd_q   <= '0;
      cnt_q   <= '0;
      clamp_q <= ld_ovf;
    end else if (state == CONVERT) begin
      bin_q   <= bin_shift;
      bcd_q   <= bcd_shift;
      cnt_q   <= cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_vld_q <= 1'b0;
      pend_val_q <= '0;
      pend_ovf_q <= 1'b0;
    end else if (start_conv) begin
      pend_vld_q <= 1'b0;
    end else if (score_valid && (state != IDLE)) begin
      pend_vld_q <= 1'b1;
      pend_val_q <= in_val;
      pend_ovf_q <= in_ovf;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      digit_hund   <= '0;
      digit_tens   <= '0;
      digit_ones   <= '0;
      digits_valid <= 1'b0;
      overflow     <= 1'b0;
    end else if (commit) begin
      digit_hund   <= bcd_q[11:8];
      digit_tens   <= bcd_q[7:4];
      digit_ones   <= bcd_q[3:0];
      digits_valid <= 1'b1;
      overflow     <= clamp_q;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_score_digit_converter.sv
// Bench for score_digit_converter: one frame-synced and one free-running instance checked against a cycle-level score model.
module tb_score_digit_converter;

  localparam int SW = 10;

  logic          clk = 1'b0;
  logic          resetn;
  logic [SW-1:0] score;
  logic          score_valid;
  logic          frame_start;

  logic       busy_s, dv_s, ovf_s, busy_f, dv_f, ovf_f;
  logic [3:0] hund_s, tens_s, ones_s, hund_f, tens_f, ones_f;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  score_digit_converter #(.SCORE_W(SW), .MAX_SCORE(999), .SYNC_TO_FRAME(1)) u_sync (
    .clk(clk), .resetn(resetn), .score(score), .score_valid(score_valid),
    .frame_start(frame_start), .busy(busy_s), .digit_hund(hund_s), .digit_tens(tens_s),
    .digit_ones(ones_s), .digits_valid(dv_s), .overflow(ovf_s)
  );

  score_digit_converter #(.SCORE_W(SW), .MAX_SCORE(999), .SYNC_TO_FRAME(0)) u_free (
    .clk(clk), .resetn(resetn), .score(score), .score_valid(score_valid),
    .frame_start(frame_start), .busy(busy_f), .digit_hund(hund_f), .digit_tens(tens_f),
    .digit_ones(ones_f), .digits_valid(dv_f), .overflow(ovf_f)
  );

  always #5 clk = ~clk;

  // Model state, index 0 = frame-synced instance, 1 = free-running instance.
  bit m_busy[2];
  int m_start[2];
  int m_val[2];
  bit m_ovf[2];
  bit m_pv[2];
  int m_pval[2];
  bit m_povf[2];
  int m_out[2];
  bit m_dv[2];
  bit m_of[2];

  function automatic int clampv(input int v);
    return (v > 999) ? 999 : v;
  endfunction

  function automatic logic [15:0] pack_exp(input int k);
    return {m_busy[k], 4'(m_out[k] / 100), 4'((m_out[k] / 10) % 10), 4'(m_out[k] % 10),
            m_dv[k], m_of[k], 2'b00};
  endfunction

  function automatic logic [15:0] pack_act(input int k);
    if (k == 0) return {busy_s, hund_s, tens_s, ones_s, dv_s, ovf_s, 2'b00};
    return {busy_f, hund_f, tens_f, ones_f, dv_f, ovf_f, 2'b00};
  endfunction

  function automatic int sync_val();
    return int'(hund_s) * 100 + int'(tens_s) * 10 + int'(ones_s);
  endfunction

  function automatic int free_val();
    return int'(hund_f) * 100 + int'(tens_f) * 10 + int'(ones_f);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Model: conversion started at edge S may commit at the first qualifying edge >= S+SW+1.
  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!resetn) begin
        m_busy[k] = 0; m_pv[k] = 0; m_out[k] = 0; m_dv[k] = 0; m_of[k] = 0;
        m_val[k] = 0; m_ovf[k] = 0; m_start[k] = 0;
      end else if (!m_busy[k]) begin
        if (score_valid) begin
          m_busy[k] = 1; m_start[k] = cyc;
          m_val[k] = clampv(int'(score)); m_ovf[k] = (score > 999);
        end
      end else if ((cyc >= m_start[k] + SW + 1) && (frame_start || k == 1)) begin
        m_out[k] = m_val[k]; m_of[k] = m_ovf[k]; m_dv[k] = 1;
        if (score_valid) begin
          m_start[k] = cyc; m_val[k] = clampv(int'(score)); m_ovf[k] = (score > 999); m_pv[k] = 0;
        end else if (m_pv[k]) begin
          m_start[k] = cyc; m_val[k] = m_pval[k]; m_ovf[k] = m_povf[k]; m_pv[k] = 0;
        end else begin
          m_busy[k] = 0;
        end
      end else if (score_valid) begin
        m_pv[k] = 1; m_pval[k] = clampv(int'(score)); m_povf[k] = (score > 999);
      end
    end
    #2;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (pack_act(k) !== pack_exp(k)) begin
        bad++;
        $display("FAIL model_cmp inst%0d cyc%0d: got %h want %h", k, cyc, pack_act(k), pack_exp(k));
      end
    end
  end

  // Called at a negedge: drive inputs, let exactly one rising edge pass.
  task automatic step(input bit v, input int s, input bit f);
    score_valid = v;
    score       = SW'(s);
    frame_start = f;
    @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0; score = '0; score_valid = 1'b0; frame_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_sync_outs", int'(pack_act(0)), 0);
    chk("reset_free_outs", int'(pack_act(1)), 0);
    resetn = 1'b1;

    for (int i = 0; i <= 16; i++) begin
      step(i == 0, 0, i == 15);
      if (i == 14) begin chk("zero_busy_wait", busy_s, 1); chk("zero_dv_wait", dv_s, 0); end
      if (i == 15) begin
        chk("zero_val", sync_val(), 0); chk("zero_dv", dv_s, 1);
        chk("zero_ovf", ovf_s, 0); chk("zero_busy_done", busy_s, 0);
      end
    end

    for (int i = 0; i <= 21; i++) begin
      step(i == 0, 259, (i == 5) || (i == 20));
      if (i == 5)  chk("s259_early_frame_ignored", sync_val(), 0);
      if (i == 19) chk("s259_hold_before_frame", sync_val(), 0);
      if (i == 20) begin chk("s259_val", sync_val(), 259); chk("s259_busy", busy_s, 0); end
    end

    for (int i = 0; i <= 12; i++) step(i == 0, 1023, i == 12);
    chk("clamp_val", sync_val(), 999);
    chk("clamp_ovf", ovf_s, 1);
    for (int i = 0; i <= 12; i++) step(i == 0, 42, i == 12);
    chk("s42_val", sync_val(), 42);
    chk("s42_ovf", ovf_s, 0);

    for (int i = 0; i <= 32; i++) begin
      step((i == 0) || (i == 3) || (i == 6), (i == 0) ? 10 : ((i == 3) ? 20 : 30), (i % 16) == 15);
      if (i <= 30) chk("pend_busy_continuous", busy_s, 1);
      if (i == 15) chk("pend_first", sync_val(), 10);
      if (i == 31) begin chk("pend_latest", sync_val(), 30); chk("pend_busy_done", busy_s, 0); end
    end

    for (int i = 0; i <= 4; i++) step(i == 0, 777, 1'b0);
    resetn = 1'b0;
    #1;
    chk("arst_busy", busy_s, 0);
    chk("arst_val", sync_val(), 0);
    chk("arst_dv", dv_s, 0);
    chk("arst_free_busy", busy_f, 0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 40; i++) step(1'b0, 0, (i % 8) == 0);
    chk("arst_no_commit_dv", dv_s, 0);
    chk("arst_no_commit_busy", busy_s, 0);

    for (int i = 0; i <= 11; i++) begin
      step(i == 0, 999, 1'b0);
      if (i == 10) begin chk("free_busy_e10", busy_f, 1); chk("free_val_e10", free_val(), 0); end
      if (i == 11) begin
        chk("free_val_e11", free_val(), 999); chk("free_busy_e11", busy_f, 0);
        chk("free_dv_e11", dv_f, 1); chk("free_ovf_e11", ovf_f, 0);
      end
    end

    for (int i = 0; i < 3000; i++) begin
      resetn = ($urandom_range(0, 399) != 0);
      step($urandom_range(0, 5) == 0,
           ($urandom_range(0, 3) == 0) ? $urandom_range(990, 1023) : $urandom_range(0, 1023),
           $urandom_range(0, 9) == 0);
    end
    resetn = 1'b1;
    step(1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
